// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit owning HI/LO: 32 shift-add or restoring-divide
// iterations on operand magnitudes, with sign handling in PREP and FIX.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  state_t             state_q;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_quo_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, div_zero_q;

  logic               is_div, is_signed;
  logic [WIDTH-1:0]   mag_a_d, mag_b_d;
  logic               b_zero_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d, div_acc_d, prod_d;
  logic [WIDTH:0]     rem_sh, trial;
  logic               fits;
  logic [WIDTH-1:0]   quo_d, rem_d, fix_hi_d, fix_lo_d;

  assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  always_comb begin
    mag_a_d  = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b_d  = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    b_zero_d = is_div && (b_q == '0);

    // Multiply: acc upper half accumulates, multiplier bits consumed from mag_b_q
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
    mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: dividend bits enter from mag_a_q; remainder < 2*divisor, so a
    // 33-bit trial difference has a trustworthy sign bit
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], mag_a_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, mag_b_q};
    fits      = ~trial[WIDTH];
    div_acc_d = {fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], fits};

    prod_d = neg_quo_q ? -acc_q : acc_q;
    quo_d  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_d  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    if (dz_q) begin
      fix_hi_d = a_q;
      fix_lo_d = '1;
    end else if (is_div) begin
      fix_hi_d = rem_d;
      fix_lo_d = quo_d;
    end else begin
      fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
      fix_lo_d = prod_d[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MULTU;
      a_q        <= '0;
      b_q        <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_t'(op);
            a_q     <= a;
            b_q     <= b;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          mag_a_q   <= mag_a_d;
          mag_b_q   <= mag_b_d;
          neg_quo_q <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem_q <= is_signed && a_q[WIDTH-1];
          acc_q     <= '0;
          cnt_q     <= '0;
          dz_q      <= b_zero_d;
          state_q   <= b_zero_d ? S_FIX : S_ITER;
        end
        S_ITER: begin
          if (is_div) begin
            acc_q   <= div_acc_d;
            mag_a_q <= mag_a_q << 1;
          end else begin
            acc_q   <= mul_acc_d;
            mag_b_q <= mag_b_q >> 1;
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q       <= fix_hi_d;
          lo_q       <= fix_lo_d;
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes arithmetic-model results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic; C-style truncating signed division
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, p, q, r;
    logic [63:0] u;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin u = {32'b0, x} * {32'b0, y}; e.hi = u[63:32]; e.lo = u[31:0]; end
      2'b01: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          e.dz = 1'b1; e.hi = x; e.lo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          e.lo = x / y; e.hi = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          e.lo = q[31:0]; e.hi = r[31:0];
        end
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual done=1 required no pending operation");
      end else begin
        e = sb_q.pop_front();
        check("hi", {32'b0, hi}, {32'b0, e.hi});
        check("lo", {32'b0, lo}, {32'b0, e.lo});
        check("div_zero", {63'b0, div_zero}, {63'b0, e.dz});
        check("busy_at_done", {63'b0, busy}, 64'd0);
      end
    end else if (div_zero) begin
      checks++;
      errors++;
      $display("FAIL div_zero_without_done: actual div_zero=1 required 0");
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit b2b, input bit disturb, input logic [31:0] hold_hi);
    int cyc, busy_cnt, lat;
    lat = (o[1] && y == 32'd0) ? 3 : 35;
    if (!b2b) @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back(model(o, x, y));
    cyc = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
      end
      if (disturb && cyc == 10) begin
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (disturb && cyc == 11) begin
        start = 1'b0; hi_we = 1'b0;
        check("mthi_dropped_busy", {32'b0, hi}, {32'b0, hold_hi});
      end
      if (busy) busy_cnt++;
    end while (!done && cyc < 100);
    check("latency", 64'(cyc), 64'(lat));
    check("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual time limit reached required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_div_zero", {63'b0, div_zero}, 64'd0);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, '0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0, '0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 0, '0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, '0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, '0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, '0);
    run_op(2'b10, 32'h1234_5678, 32'h0000_0000, 0, 0, '0);
    run_op(2'b00, 32'd9, 32'd11, 1, 0, '0);

    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", {32'b0, hi}, 64'h5A5A_5A5A);
    check("mt_both_lo", {32'b0, lo}, 64'h5A5A_5A5A);
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk); hi_we = 1'b0;
    check("mthi", {32'b0, hi}, 64'hAAAA_5555);
    check("mthi_lo_kept", {32'b0, lo}, 64'h5A5A_5A5A);
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk); lo_we = 1'b0;
    check("mtlo", {32'b0, lo}, 64'h0000_1234);
    check("mtlo_hi_kept", {32'b0, hi}, 64'hAAAA_5555);

    run_op(2'b00, 32'd3, 32'd4, 0, 1, 32'hAAAA_5555);

    // MTLO in the same cycle as an accepted start lands, FIX overwrites later
    @(negedge clk); op = 2'b10; a = 32'd1000; b = 32'd9; start = 1'b1; lo_we = 1'b1; wdata = 32'h77;
    sb_q.push_back(model(2'b10, 32'd1000, 32'd9));
    @(negedge clk); start = 1'b0; lo_we = 1'b0;
    check("mtlo_with_start", {32'b0, lo}, 64'h77);
    seen = 0;
    while (!done && seen < 100) begin @(negedge clk); seen++; end
    check("mtlo_start_done", {63'b0, done}, 64'd1);

    @(negedge clk); op = 2'b11; a = 32'hFFFF_0000; b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_div_zero", {63'b0, div_zero}, 64'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    check("abort_no_done", 64'(seen), 64'd0);

    run_op(2'b10, 32'd100, 32'd7, 0, 0, '0);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), pick(), pick(), bit'($urandom_range(0, 1)), 0, '0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
